// File: rtl/ram_rwsp_128x16_pkg.sv
// Shared geometry for the 128x16 single-port-per-direction RAM and a
// helper that detects same-address read/write contention.
package ram_rwsp_128x16_pkg;

   localparam int RAM_DEPTH = 128;
   localparam int RAM_AW    = 7;
   localparam int RAM_DW    = 16;
   localparam int RAM_PWR_W = 32;

   function automatic logic rw_contention(input logic          we,
                                          input logic          re,
                                          input logic [RAM_AW-1:0] wa,
                                          input logic [RAM_AW-1:0] ra);
      return we && re && (wa == ra);
   endfunction

endpackage

// File: rtl/ram_rwsp_128x16_array.sv
// Storage array: one synchronous write port and a combinational read port
// addressed by the registered read address held in the top level.
module ram_rwsp_128x16_array
   import ram_rwsp_128x16_pkg::*;
(
   input  logic              clk,
   input  logic              i_we,
   input  logic [RAM_AW-1:0] i_wa,
   input  logic [RAM_DW-1:0] i_di,
   input  logic [RAM_AW-1:0] i_ra,
   output logic [RAM_DW-1:0] o_rd
);

   logic [RAM_DW-1:0] r_mem [RAM_DEPTH];

   // No reset on the array: contents survive reset by design.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_wa] <= i_di;
      end
   end

   assign o_rd = r_mem[i_ra];

endmodule

// File: rtl/ram_rwsp_128x16.sv
// 128x16 RAM with separate write and read ports and a two-edge read
// pipeline (re latches the address, ore loads the output register).
module ram_rwsp_128x16
   import ram_rwsp_128x16_pkg::*;
#(
   parameter logic FORCE_CONTENTION_ASSERTION_RESET_ACTIVE = 1'b1
) (
   input  logic                 clk,
   input  logic                 reset_,
   input  logic [RAM_PWR_W-1:0] pwrbus_ram_pd,
   input  logic [RAM_AW-1:0]    wa,
   input  logic                 we,
   input  logic [RAM_DW-1:0]    di,
   input  logic [RAM_AW-1:0]    ra,
   input  logic                 re,
   input  logic                 ore,
   output logic [RAM_DW-1:0]    dout
);

   logic [RAM_AW-1:0] r_ra_q;
   logic [RAM_DW-1:0] r_dout;
   logic [RAM_DW-1:0] w_rd;
   logic              w_we;
   logic              w_unused_pwrbus;

   // Power-down bus is carried for integration only; it never gates storage.
   assign w_unused_pwrbus = ^pwrbus_ram_pd;

   // Writes are suppressed while reset is held so the array sees no stray edge.
   assign w_we = we & reset_;

   ram_rwsp_128x16_array u_array (
      .clk  (clk),
      .i_we (w_we),
      .i_wa (wa),
      .i_di (di),
      .i_ra (r_ra_q),
      .o_rd (w_rd)
   );

   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         r_ra_q <= '0;
         r_dout <= '0;
      end else begin
         if (re) begin
            r_ra_q <= ra;
         end
         // w_rd reflects the array before this edge's write: read-before-write.
         if (ore) begin
            r_dout <= w_rd;
         end
      end
   end

   assign dout = r_dout;

`ifndef SYNTHESIS
   always @(posedge clk) begin
      if (!FORCE_CONTENTION_ASSERTION_RESET_ACTIVE && reset_) begin
         assert (!rw_contention(we, re, wa, ra))
            else $warning("ram_rwsp_128x16: read/write contention at address %0d", wa);
      end
   end
`endif

endmodule

// File: tb/tb_ram_rwsp_128x16.sv
// Self-checking bench for ram_rwsp_128x16: directed steps plus random traffic
// checked against an array-level behavioural model.
module tb_ram_rwsp_128x16;

   logic        clk = 1'b0;
   logic        reset_;
   logic [31:0] pwrbus_ram_pd;
   logic [6:0]  wa, ra;
   logic        we, re, ore;
   logic [15:0] di;
   logic [15:0] dout;

   int n_cmp = 0;
   int n_err = 0;

   // Behavioural model: the memory, the latched read address, the output word.
   logic [15:0] m_mem [128];
   logic [6:0]  m_raq;
   logic [15:0] m_dout;

   ram_rwsp_128x16 dut (
      .clk           (clk),
      .reset_        (reset_),
      .pwrbus_ram_pd (pwrbus_ram_pd),
      .wa            (wa),
      .we            (we),
      .di            (di),
      .ra            (ra),
      .re            (re),
      .ore           (ore),
      .dout          (dout)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp)
         else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
         end
   endtask

   // Apply one cycle of inputs, advance the model by the read/write rules,
   // then compare dout shortly after the edge.
   task automatic step(input logic iwe, input logic [6:0] iwa, input logic [15:0] idi,
                       input logic ire, input logic [6:0] ira, input logic iore);
      we = iwe; wa = iwa; di = idi; re = ire; ra = ira; ore = iore;
      pwrbus_ram_pd = $urandom;
      @(posedge clk);
      if (reset_) begin
         if (iore) m_dout = m_mem[m_raq];
         if (ire)  m_raq  = ira;
         if (iwe)  m_mem[iwa] = idi;
      end
      #1;
      check("step_dout", dout, m_dout);
   endtask

   initial begin
      reset_ = 1'b0;
      we = 0; re = 0; ore = 0; wa = 0; ra = 0; di = 0; pwrbus_ram_pd = 0;
      m_raq = 0; m_dout = 0;
      #3;
      check("reset_state", dout, 16'h0000);
      @(posedge clk); #1;
      check("reset_hold", dout, 16'h0000);
      #2 reset_ = 1'b1;

      // Fill every location so later reads are always defined.
      for (int i = 0; i < 128; i++) step(1'b1, 7'(i), 16'($urandom), 1'b0, 7'd0, 1'b0);
      check("fill_no_dout", dout, 16'h0000);

      // Basic write then two-edge read.
      step(1'b1, 7'd5, 16'hA5A5, 1'b0, 7'd0, 1'b0);
      step(1'b0, 7'd0, 16'h0000, 1'b1, 7'd5, 1'b0);
      step(1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 1'b1);
      check("wr_rd_5", dout, 16'hA5A5);

      // Output holds while ore is low, then picks up the new address.
      step(1'b1, 7'd6, 16'h1234, 1'b0, 7'd0, 1'b0);
      step(1'b0, 7'd0, 16'h0000, 1'b1, 7'd6, 1'b0);
      check("hold_a5a5", dout, 16'hA5A5);
      step(1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 1'b0);
      check("idle_hold", dout, 16'hA5A5);
      step(1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 1'b1);
      check("load_1234", dout, 16'h1234);

      // Address extremes.
      step(1'b1, 7'd127, 16'hFFFF, 1'b0, 7'd0, 1'b0);
      step(1'b1, 7'd0,   16'h0001, 1'b1, 7'd127, 1'b0);
      step(1'b0, 7'd0,   16'h0000, 1'b1, 7'd0,   1'b1);
      check("bound_127", dout, 16'hFFFF);
      step(1'b0, 7'd0,   16'h0000, 1'b0, 7'd0,   1'b1);
      check("bound_0", dout, 16'h0001);

      // Read-before-write on the output stage.
      step(1'b1, 7'd9, 16'h1111, 1'b0, 7'd0, 1'b0);
      step(1'b0, 7'd0, 16'h0000, 1'b1, 7'd9, 1'b0);
      step(1'b1, 7'd9, 16'h2222, 1'b0, 7'd0, 1'b1);
      check("rbw_old", dout, 16'h1111);
      step(1'b0, 7'd0, 16'h0000, 1'b1, 7'd9, 1'b0);
      step(1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 1'b1);
      check("rbw_new", dout, 16'h2222);

      // re and ore together: dout from old address, address updates.
      step(1'b0, 7'd0, 16'h0000, 1'b1, 7'd5, 1'b1);
      check("re_ore_old", dout, 16'h2222);
      step(1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 1'b1);
      check("re_ore_new", dout, 16'hA5A5);

      // Streaming: fill addr*3, then read back with no bubbles.
      for (int i = 0; i < 128; i++) step(1'b1, 7'(i), 16'(i * 3), 1'b0, 7'd0, 1'b0);
      for (int i = 0; i <= 128; i++) begin
         step(1'b0, 7'd0, 16'h0000, i < 128, 7'(i), i > 0);
         if (i > 0) check("stream", dout, 16'((i - 1) * 3));
      end

      // Random traffic including same-address contention and simultaneous ports.
      for (int i = 0; i < 300; i++)
         step(1'($urandom), 7'($urandom), 16'($urandom), 1'($urandom), 7'($urandom), 1'($urandom));

      // Asynchronous reset after a read, with ore held high.
      step(1'b1, 7'd0, 16'h00C3, 1'b0, 7'd0, 1'b0);
      step(1'b1, 7'd3, 16'h5A5A, 1'b1, 7'd3, 1'b0);
      step(1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 1'b1);
      check("pre_reset", dout, 16'h5A5A);
      ore = 1'b1;
      #2 reset_ = 1'b0;
      #1;
      m_raq = 0; m_dout = 0;
      check("async_reset", dout, 16'h0000);
      for (int i = 0; i < 3; i++) step(1'b1, 7'd3, 16'hDEAD, 1'b1, 7'd3, 1'b1);
      check("reset_ignores", dout, 16'h0000);
      #2 reset_ = 1'b1;
      step(1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 1'b1);
      check("post_reset_mem0", dout, 16'h00C3);
      step(1'b0, 7'd0, 16'h0000, 1'b1, 7'd3, 1'b0);
      step(1'b0, 7'd0, 16'h0000, 1'b0, 7'd0, 1'b1);
      check("retained_3", dout, 16'h5A5A);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ram_rwsp_128x16.md
RAM_RWSP_128X16 -- requirements
Module: ram_rwsp_128x16

Interface
REQ-001 Parameter FORCE_CONTENTION_ASSERTION_RESET_ACTIVE, default 1'b1; when 1, the read/write contention check is held inactive (treated as in reset) and never fires.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_  input  1  asynchronous active-low reset.
REQ-005 pwrbus_ram_pd  input  32  RAM power-down bus; no functional effect in RTL; contents always retained.
REQ-006 wa  input  7  write address.
REQ-007 we  input  1  write enable.
REQ-008 di  input  16  write data.
REQ-009 ra  input  7  read address.
REQ-010 re  input  1  read enable; latches ra.
REQ-011 ore  input  1  output-register enable.
REQ-012 dout  output  16  registered read data.

Function
REQ-013 Storage SHALL be 128 words x 16 bits, addresses 0..127, no wrap logic (7-bit address covers the whole array).
REQ-014 Write: at a clk edge with we=1, mem[wa] <= di; we=0 leaves the array unchanged.
REQ-015 Read stage 1: at a clk edge with re=1, ra SHALL be captured into an internal read-address register ra_q; re=0 holds ra_q.
REQ-016 Read stage 2: at a clk edge with ore=1, dout SHALL be loaded with mem[ra_q] as it stands before that edge's write; ore=0 holds dout.
REQ-017 Latency: re at edge N, ore at edge N+1 -> data valid on dout after edge N+1 (two-edge read pipeline).
REQ-018 re and ore are independent; both asserted in the same cycle loads dout from the old ra_q while ra_q takes the new ra.
REQ-019 Write at edge N followed by a read of the same address with re at N+1 (or later) SHALL return the new data.
REQ-020 Write to address A at the same edge that ore loads from ra_q=A SHALL yield the old contents of A (read-before-write).
REQ-021 Contention (we=1 and re=1 with wa==ra in the same cycle) is legal and the data is later discarded by the user; when the parameter is 0, a simulation-only check SHALL report it; when 1, no report.
REQ-022 we, re, ore all 0: no state change.
REQ-023 Simultaneous we and re to different addresses SHALL both complete in the same cycle (one write port, one read port).

Reset
REQ-024 reset_=0 SHALL clear ra_q to 0 and dout to 16'h0000 immediately (asynchronously).
REQ-025 Array contents SHALL NOT be reset; they are retained through reset assertion mid-operation.
REQ-026 While reset_=0, we/re/ore are ignored; the first edge after deassertion operates normally.

Structure
REQ-027 Shared package SHALL hold RAM_DEPTH=128, RAM_AW=7, RAM_DW=16, and the 32-bit power-bus width constant.
REQ-028 One sub-module is natural: ram_rwsp_128x16_array (storage plus write port and combinational read at ra_q). The top level holds ra_q, the dout register and the contention check.
REQ-029 The design SHALL be synthesizable; the contention check SHALL be excluded from synthesis.

Verification
REQ-030 Reset: assert reset_ with ore=1 after a prior read -> dout=0 immediately, stays 0 until the next ore edge after release.
REQ-031 Write/read: we wa=5 di=16'hA5A5; next cycle re ra=5; next cycle ore=1 -> dout=16'hA5A5 after that edge.
REQ-032 Hold: after REQ-031, ore=0 and re with ra=6 (mem[6]=16'h1234) -> dout stays 16'hA5A5 until ore=1, then 16'h1234.
REQ-033 Boundaries: write 16'hFFFF to 127 and 16'h0001 to 0, read back 127 then 0 -> 16'hFFFF then 16'h0001.
REQ-034 Read-before-write: ra_q=9 holding 16'h1111; same edge we wa=9 di=16'h2222 and ore=1 -> dout=16'h1111; re ra=9 then ore -> 16'h2222.
REQ-035 Streaming: writes to 0..127 with data=addr*3, reads with re every cycle and ore one cycle later -> dout sequence matches with no bubbles; pwrbus_ram_pd toggled randomly has no effect.
